i2s_pcm_sched: RTL
==================

Name: i2s_pcm_sched

Overview:
- Sample scheduler and arbiter in front of the 2-channel I2S serializer for the PCM5102 DAC.
- Two requesters share one stereo sample FIFO: port 0 is the DMA/stream engine, port 1 is CPU register writes.
- Once per audio frame the block pops one {l,r} pair and holds it stable on l_out/r_out for the serializer to latch.
- Underrun policy is configurable. Underruns are counted and reported.

Parameters:
- depth_log2, 3, FIFO depth = 2**depth_log2 stereo entries (allowed 2..6)
- pop_edge, 1, 1: pop on lrck rising edge; 0: pop on lrck falling edge
- urun_bits, 16, width of the saturating underrun counter

Ports:
- clk  in  1  system clock, same domain as the serializer
- reset  in  1  asynchronous, active-high
- lrck  in  1  L/R clock fed back from the serializer
- enable  in  1  1: scheduling active; 0: FIFO flushed, outputs muted
- hold_last  in  1  underrun policy; 1: repeat last sample; 0: output zero
- req0_valid  in  1  DMA sample valid
- req0_data  in  32  DMA sample {l[15:0], r[15:0]}
- req0_ready  out  1  DMA sample accepted this cycle
- req1_valid  in  1  CPU sample valid
- req1_data  in  32  CPU sample {l, r}
- req1_ready  out  1  CPU sample accepted this cycle
- l_out  out  16  signed PCM left channel, to serializer l
- r_out  out  16  signed PCM right channel, to serializer r
- level  out  depth_log2+1  current FIFO occupancy
- frame_tick  out  1  one-cycle pulse, high in the cycle a pop decision is made
- underrun  out  1  sticky flag; cleared by urun_clr
- urun_clr  in  1  clears underrun and urun_cnt
- urun_cnt  out  urun_bits  saturating count of underrun frames

Behaviour:
- Reset values: FIFO empty, level=0, l_out=r_out=0, req*_ready=0, frame_tick=0, underrun=0, urun_cnt=0, lrck history register=0.
- Edge detect:
  - lrck_d is lrck registered once.
  - The pop edge is lrck & ~lrck_d when pop_edge=1, or ~lrck & lrck_d when pop_edge=0.
  - frame_tick is asserted in the cycle after the edge is seen (1-cycle latency).
  - lrck is synchronous to clk, so no synchronizer is used.
- Arbitration:
  - Round-robin between req0 and req1 with a 1-bit last-grant pointer. Pointer reset value = 1, so req0 wins the first tie.
  - At most one write per cycle.
  - reqN_ready = grantN & ~full & enable. It is a combinational function of valid, full, enable and the pointer.
  - A transfer happens when valid & ready are both high. The pointer updates only on a transfer.
  - A requester holds valid and data until ready. The arbiter never grants a requester whose valid is low.
- FIFO:
  - Circular buffer with rd_ptr/wr_ptr of depth_log2+1 bits. The MSB distinguishes full from empty.
  - Pointers wrap modulo 2**(depth_log2+1).
  - full = level == 2**depth_log2. Writes are refused when full.
- Pop, in a frame_tick cycle:
  - FIFO non-empty: {l_out, r_out} are loaded from the head entry at the next edge and rd_ptr is incremented.
  - FIFO empty: underrun is set, urun_cnt increments (saturating at all-ones), and the outputs either hold (hold_last=1) or go to 0 (hold_last=0).
- Simultaneous write and pop in the same cycle, at any level, including empty and full:
  - Empty: the pop is an underrun. The written sample is enqueued and level ends at 1.
  - Full: the write is refused, because ready is computed from pre-pop full. The pop proceeds and level ends at full-1.
  - Otherwise: level is unchanged.
- Outputs l_out and r_out change only in the cycle after frame_tick. They are stable for the rest of the frame.
- enable=0:
  - FIFO flushed (pointers reset), ready=0, frame_tick still pulses.
  - l_out and r_out forced to 0 at the next frame_tick. No underrun is counted.
- enable 0->1:
  - Accepting starts the next cycle.
  - The first pop happens at the next frame_tick. An underrun is counted only if the FIFO is empty at that tick.
- urun_clr: a synchronous clear that takes priority over an underrun increment in the same cycle.
- Reset asserted mid-operation: all state returns to its reset value immediately, and pending requester transfers are lost.

Decomposition:
- Shared package:
  - Sample width constant 16 and stereo word width 32.
  - Field slices: l = [31:16], r = [15:0].
  - Underrun policy encodings.
- One sub-module is natural: i2s_pcm_fifo.
  - Synchronous circular buffer with write port, pop strobe, head output, level, full and empty.
  - It maps to distributed RAM.
- Arbiter, edge detect and underrun logic stay in the top module.

Test Plan:
- Reset, then enable=1 with both requesters idle, for 3 frames -> l_out=r_out=0 throughout, underrun=1, urun_cnt=3.
- req0 pushes 0x1234_ABCD, 0x0001_FFFF -> at frame_tick 1: l_out=0x1234, r_out=0xABCD; at tick 2: l_out=0x0001, r_out=0xFFFF; level goes 2, 1, 0.
- req0 and req1 both held valid continuously with FIFO draining -> grants alternate 0,1,0,1. With depth_log2=3: level=8 after 8 writes, both ready=0 while full.
- Level 8 (full) with a write and a frame_tick in the same cycle -> write refused, level=7, ready reasserted next cycle.
- hold_last=1, last sample 0x7FFF_8000, then FIFO runs empty -> outputs stay 0x7FFF/0x8000 and urun_cnt increments once per frame. Same sequence with hold_last=0 -> outputs 0.
- Assert reset mid-stream at level 5 -> level=0, outputs 0, underrun=0 immediately. Assert urun_clr on the same cycle as an underrun tick -> urun_cnt=0.

Source files
------------

// File: rtl/i2s_pcm_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_pcm_sched_pkg : shared widths, stereo field slices, underrun policy. Rev 1.0
// ---------------------------------------------------------------------------
package i2s_pcm_sched_pkg;

  localparam int unsigned c_sample_w = 16;
  localparam int unsigned c_stereo_w = 32;

  typedef logic [c_sample_w-1:0] sample_t;
  typedef logic [c_stereo_w-1:0] stereo_t;

  typedef enum logic {
    URUN_ZERO = 1'b0,
    URUN_HOLD = 1'b1
  } urun_policy_e;

  function automatic sample_t left_of(input stereo_t w);
    return w[31:16];
  endfunction

  function automatic sample_t right_of(input stereo_t w);
    return w[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_pcm_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_pcm_fifo : circular stereo-sample buffer, head-of-queue read. Rev 1.0
// ---------------------------------------------------------------------------
module i2s_pcm_fifo
  import i2s_pcm_sched_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  input  logic                wr_en_i,
  input  logic [c_stereo_w-1:0] wr_data_i,
  input  logic                pop_i,
  output logic [c_stereo_w-1:0] head_o,
  output logic [DEPTH_LOG2:0] level_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int unsigned c_depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_one = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] c_full_lvl = (DEPTH_LOG2+1)'(c_depth);

  stereo_t             mem_q [c_depth];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                w_do_wr;
  logic                w_do_pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign level_o  = wr_ptr_q - rd_ptr_q;
  assign full_o   = (level_o == c_full_lvl);
  assign empty_o  = (level_o == '0);
  assign w_do_wr  = wr_en_i & ~full_o & ~flush_i;
  assign w_do_pop = pop_i & ~empty_o & ~flush_i;
  assign head_o   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_do_wr)  wr_ptr_d = wr_ptr_q + c_one;
      if (w_do_pop) rd_ptr_d = rd_ptr_q + c_one;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/i2s_pcm_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_pcm_sched : two-port sample arbiter + per-frame pop for I2S DAC. Rev 1.0
// ---------------------------------------------------------------------------
module i2s_pcm_sched
  import i2s_pcm_sched_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned POP_EDGE   = 1,
  parameter int unsigned URUN_BITS  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  lrck_i,
  input  logic                  enable_i,
  input  logic                  hold_last_i,
  input  logic                  req0_valid_i,
  input  logic [c_stereo_w-1:0] req0_data_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [c_stereo_w-1:0] req1_data_i,
  output logic                  req1_ready_o,
  output logic [c_sample_w-1:0] l_out_o,
  output logic [c_sample_w-1:0] r_out_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  frame_tick_o,
  output logic                  underrun_o,
  input  logic                  urun_clr_i,
  output logic [URUN_BITS-1:0]  urun_cnt_o
);

  logic                 lrck_d_q;
  logic                 frame_tick_q;
  logic                 en_q;
  logic                 last_q, last_d;
  logic                 underrun_q, underrun_d;
  logic [URUN_BITS-1:0] urun_cnt_q, urun_cnt_d;
  sample_t              l_q, l_d;
  sample_t              r_q, r_d;

  logic                 w_pop_edge;
  logic                 w_grant0, w_grant1;
  logic                 w_xfer0, w_xfer1;
  logic                 w_wr_en;
  stereo_t              w_wr_data;
  stereo_t              w_head;
  logic                 w_full, w_empty;
  logic                 w_pop, w_urun;
  urun_policy_e         w_policy;

  if (POP_EDGE != 0) begin : g_pop_rise
    assign w_pop_edge = lrck_i & ~lrck_d_q;
  end else begin : g_pop_fall
    assign w_pop_edge = ~lrck_i & lrck_d_q;
  end

  // last_q = 1 means req1 was granted last, so req0 wins the next tie.
  assign w_grant0     = req0_valid_i & (~req1_valid_i | last_q);
  assign w_grant1     = req1_valid_i & (~req0_valid_i | ~last_q);
  assign req0_ready_o = w_grant0 & ~w_full & en_q;
  assign req1_ready_o = w_grant1 & ~w_full & en_q;
  assign w_xfer0      = req0_valid_i & req0_ready_o;
  assign w_xfer1      = req1_valid_i & req1_ready_o;
  assign w_wr_en      = w_xfer0 | w_xfer1;
  assign w_wr_data    = w_xfer1 ? req1_data_i : req0_data_i;

  assign w_pop    = frame_tick_q & en_q & ~w_empty;
  assign w_urun   = frame_tick_q & en_q & w_empty;
  assign w_policy = urun_policy_e'(hold_last_i);

  i2s_pcm_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .flush_i   (~en_q),
    .wr_en_i   (w_wr_en),
    .wr_data_i (w_wr_data),
    .pop_i     (w_pop),
    .head_o    (w_head),
    .level_o   (level_o),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  always_comb begin
    last_d     = last_q;
    l_d        = l_q;
    r_d        = r_q;
    underrun_d = underrun_q;
    urun_cnt_d = urun_cnt_q;

    if (w_xfer0)      last_d = 1'b0;
    else if (w_xfer1) last_d = 1'b1;

    if (frame_tick_q) begin
      if (!en_q) begin
        l_d = '0;
        r_d = '0;
      end else if (!w_empty) begin
        l_d = left_of(w_head);
        r_d = right_of(w_head);
      end else if (w_policy == URUN_ZERO) begin
        l_d = '0;
        r_d = '0;
      end
    end

    // Clear wins over an underrun landing in the same cycle.
    if (urun_clr_i) begin
      underrun_d = 1'b0;
      urun_cnt_d = '0;
    end else if (w_urun) begin
      underrun_d = 1'b1;
      if (urun_cnt_q != '1) urun_cnt_d = urun_cnt_q + URUN_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lrck_d_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      en_q         <= 1'b0;
      last_q       <= 1'b1;
      underrun_q   <= 1'b0;
      urun_cnt_q   <= '0;
      l_q          <= '0;
      r_q          <= '0;
    end else begin
      lrck_d_q     <= lrck_i;
      frame_tick_q <= w_pop_edge;
      en_q         <= enable_i;
      last_q       <= last_d;
      underrun_q   <= underrun_d;
      urun_cnt_q   <= urun_cnt_d;
      l_q          <= l_d;
      r_q          <= r_d;
    end
  end

  assign l_out_o      = l_q;
  assign r_out_o      = r_q;
  assign frame_tick_o = frame_tick_q;
  assign underrun_o   = underrun_q;
  assign urun_cnt_o   = urun_cnt_q;

endmodule
`default_nettype wire
